// File: rtl/spu_issue_buffer_pkg.sv
// Shared types for the SPU instruction fetch/issue buffer.
package spu_pkg;

  localparam int INSTS_PER_QW = 4;
  // Local-store address width carried in every buffered entry.
  localparam int IBUF_PC_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } fetch_state_t;

  typedef struct packed {
    logic [31:0]           inst;
    logic [IBUF_PC_W-1:0]  pc;
  } ibuf_entry_t;

endpackage

// File: rtl/spu_issue_buffer_ram.sv
// DEPTH-entry instruction store: four write lanes with per-lane enable,
// two combinational read lanes. Pointer arithmetic lives in the parent.
module spu_ibuf_ram
  import spu_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                               clk,
  input  logic [INSTS_PER_QW-1:0]            we,
  input  logic [INSTS_PER_QW-1:0][AW-1:0]    waddr,
  input  ibuf_entry_t [INSTS_PER_QW-1:0]     wdata,
  input  logic [AW-1:0]                      raddr1,
  input  logic [AW-1:0]                      raddr2,
  output ibuf_entry_t                        rdata1,
  output ibuf_entry_t                        rdata2
);

  ibuf_entry_t mem [DEPTH];

  // Enabled lanes always target distinct entries, so lane order is irrelevant.
  always_ff @(posedge clk) begin
    for (int i = 0; i < INSTS_PER_QW; i++) begin
      if (we[i]) begin
        mem[waddr[i]] <= wdata[i];
      end
    end
  end

  assign rdata1 = mem[raddr1];
  assign rdata2 = mem[raddr2];

endmodule

// File: rtl/spu_issue_buffer.sv
// Fetch/issue buffer: fetches quadwords from local store and presents up to
// two in-order instructions per cycle to the ID1/ID2 decoders.
module spu_issue_buffer
  import spu_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int LSA_W = IBUF_PC_W
) (
  input  logic              clk,
  input  logic              reset,
  output logic              fetch_req,
  output logic [LSA_W-1:0]  fetch_addr,
  input  logic              fetch_gnt,
  input  logic              fetch_rvalid,
  input  logic [127:0]      fetch_rdata,
  input  logic              issue_stall,
  output logic              inst_valid1,
  output logic [31:0]       inst1,
  output logic [LSA_W-1:0]  inst_pc1,
  output logic              inst_valid2,
  output logic [31:0]       inst2,
  output logic [LSA_W-1:0]  inst_pc2,
  input  logic              flush,
  input  logic [LSA_W-1:0]  flush_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_state_t       state_reg;
  logic [AW-1:0]      rd_ptr_reg;
  logic [AW-1:0]      wr_ptr_reg;
  logic [CW-1:0]      count_reg;
  logic [LSA_W-1:0]   fetch_pc_reg;
  logic [1:0]         skip_reg;
  logic               drop_next_reg;

  logic               valid1;
  logic               valid2;
  logic [1:0]         pop;
  logic               rsp_accept;
  logic [2:0]         wr_n;
  logic [CW-1:0]      space;
  logic [INSTS_PER_QW-1:0]          word_mask;
  logic [INSTS_PER_QW-1:0]          we;
  logic [INSTS_PER_QW-1:0][AW-1:0]  waddr;
  ibuf_entry_t [INSTS_PER_QW-1:0]   wdata;
  ibuf_entry_t        head1;
  ibuf_entry_t        head2;
  logic               flush_pc_unused;

  assign flush_pc_unused = ^flush_pc[1:0];

  assign valid1 = (count_reg != '0);
  assign valid2 = (count_reg > CW'(1));
  assign pop    = issue_stall ? 2'd0 : ({1'b0, valid1} + {1'b0, valid2});
  assign space  = CW'(DEPTH) - count_reg + CW'(pop);

  // A response is only written when it belongs to the current fetch stream.
  assign rsp_accept = (state_reg == WAIT) && fetch_rvalid && !drop_next_reg && !flush;
  assign wr_n       = 3'(INSTS_PER_QW) - {1'b0, skip_reg};
  assign word_mask  = 4'b1111 << skip_reg;
  assign we         = rsp_accept ? word_mask : '0;

  for (genvar gi = 0; gi < INSTS_PER_QW; gi++) begin : g_wr
    assign waddr[gi] = wr_ptr_reg + AW'(gi) - AW'(skip_reg);
    assign wdata[gi] = '{inst: fetch_rdata[127-32*gi -: 32],
                         pc:   {fetch_pc_reg[LSA_W-1:4], 2'(gi), 2'b00}};
  end

  spu_ibuf_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk    (clk),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .raddr1 (rd_ptr_reg),
    .raddr2 (rd_ptr_reg + AW'(1)),
    .rdata1 (head1),
    .rdata2 (head2)
  );

  assign inst_valid1 = valid1;
  assign inst1       = valid1 ? head1.inst : '0;
  assign inst_pc1    = valid1 ? head1.pc   : '0;
  assign inst_valid2 = valid2;
  assign inst2       = valid2 ? head2.inst : '0;
  assign inst_pc2    = valid2 ? head2.pc   : '0;

  assign fetch_req  = (state_reg == REQ);
  assign fetch_addr = {fetch_pc_reg[LSA_W-1:4], 4'b0000};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      rd_ptr_reg    <= '0;
      wr_ptr_reg    <= '0;
      count_reg     <= '0;
      fetch_pc_reg  <= '0;
      skip_reg      <= '0;
      drop_next_reg <= 1'b0;
    end else if (flush) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      fetch_pc_reg <= {flush_pc[LSA_W-1:4], 4'b0000};
      skip_reg     <= flush_pc[3:2];
      // A granted-but-unreturned request must have its response swallowed.
      case (state_reg)
        REQ: begin
          if (fetch_gnt) begin
            state_reg     <= WAIT;
            drop_next_reg <= 1'b1;
          end else begin
            state_reg <= IDLE;
          end
        end
        WAIT: begin
          if (fetch_rvalid) begin
            state_reg     <= IDLE;
            drop_next_reg <= 1'b0;
          end else begin
            drop_next_reg <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end else begin
      rd_ptr_reg <= rd_ptr_reg + AW'(pop);
      count_reg  <= count_reg + (rsp_accept ? CW'(wr_n) : CW'(0)) - CW'(pop);
      if (rsp_accept) begin
        wr_ptr_reg   <= wr_ptr_reg + AW'(wr_n);
        fetch_pc_reg <= fetch_pc_reg + LSA_W'(16);
        skip_reg     <= 2'd0;
      end
      case (state_reg)
        IDLE: if (space >= CW'(INSTS_PER_QW)) state_reg <= REQ;
        REQ:  if (fetch_gnt) state_reg <= WAIT;
        WAIT: begin
          if (fetch_rvalid) begin
            state_reg     <= IDLE;
            drop_next_reg <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spu_issue_buffer.sv
// Bench for spu_issue_buffer: queue-level reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_spu_issue_buffer;

  localparam int DEPTH = 8;
  localparam int LSA_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              fetch_req;
  logic [LSA_W-1:0]  fetch_addr;
  logic              fetch_gnt;
  logic              fetch_rvalid;
  logic [127:0]      fetch_rdata;
  logic              issue_stall;
  logic              inst_valid1;
  logic [31:0]       inst1;
  logic [LSA_W-1:0]  inst_pc1;
  logic              inst_valid2;
  logic [31:0]       inst2;
  logic [LSA_W-1:0]  inst_pc2;
  logic              flush;
  logic [LSA_W-1:0]  flush_pc;

  always #5 clk = ~clk;

  spu_issue_buffer #(.DEPTH(DEPTH), .LSA_W(LSA_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .fetch_req    (fetch_req),
    .fetch_addr   (fetch_addr),
    .fetch_gnt    (fetch_gnt),
    .fetch_rvalid (fetch_rvalid),
    .fetch_rdata  (fetch_rdata),
    .issue_stall  (issue_stall),
    .inst_valid1  (inst_valid1),
    .inst1        (inst1),
    .inst_pc1     (inst_pc1),
    .inst_valid2  (inst_valid2),
    .inst2        (inst2),
    .inst_pc2     (inst_pc2),
    .flush        (flush),
    .flush_pc     (flush_pc)
  );

  // Reference model: the buffer is a queue of {inst, pc}; fetch progress is
  // tracked as idle / requesting / waiting with a drop-next flag.
  typedef struct {
    logic [31:0] inst;
    logic [15:0] pc;
  } ment_t;

  ment_t       mq[$];
  int          mphase = 0;
  logic [15:0] mfpc   = '0;
  logic [1:0]  mskip  = '0;
  bit          mdrop  = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b1;

  // Local-store responder and stimulus knobs.
  bit          pend      = 1'b0;
  int          wait_cnt  = 0;
  logic [15:0] pend_addr = '0;
  logic [15:0] gnt_addr  = '0;
  logic [15:0] salt      = '0;
  bit          hold_rst  = 1'b1;
  int gnt_pct = 100, lat_min = 1, lat_max = 1, stall_pct = 0, flush_pct = 0, rst_pct = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] ls_word(logic [15:0] a);
    return {salt, 16'((a >> 2) + 16'd1)};
  endfunction

  task automatic model_step();
    int   sz;
    int   pop;
    ment_t e;
    sz = mq.size();
    if (reset) begin
      mq.delete();
      mphase = 0; mfpc = '0; mskip = '0; mdrop = 1'b0;
      return;
    end
    pop = issue_stall ? 0 : ((sz >= 2) ? 2 : sz);
    if (flush) begin
      mq.delete();
      mfpc  = {flush_pc[15:4], 4'h0};
      mskip = flush_pc[3:2];
      if (mphase == 1) begin
        if (fetch_gnt) begin mphase = 2; mdrop = 1'b1; end
        else mphase = 0;
      end else if (mphase == 2) begin
        if (fetch_rvalid) begin mphase = 0; mdrop = 1'b0; end
        else mdrop = 1'b1;
      end
      return;
    end
    repeat (pop) void'(mq.pop_front());
    case (mphase)
      0: if (DEPTH - sz + pop >= 4) mphase = 1;
      1: if (fetch_gnt) mphase = 2;
      default: begin
        if (fetch_rvalid) begin
          if (!mdrop) begin
            for (int w = int'(mskip); w < 4; w++) begin
              e.inst = fetch_rdata[127-32*w -: 32];
              e.pc   = {mfpc[15:4], 2'(w), 2'b00};
              mq.push_back(e);
            end
            mfpc  = mfpc + 16'd16;
            mskip = 2'd0;
          end
          mdrop  = 1'b0;
          mphase = 0;
        end
      end
    endcase
  endtask

  // One clock: update model and responder from the edge, then drive new inputs.
  task automatic cycle();
    @(posedge clk);
    model_step();
    if (fetch_rvalid) pend = 1'b0;
    if (fetch_gnt) begin
      pend      = 1'b1;
      pend_addr = gnt_addr;
      wait_cnt  = $urandom_range(lat_max, lat_min) - 1;
    end else if (pend && wait_cnt > 0) begin
      wait_cnt--;
    end
    #1;
    fetch_rvalid = pend && (wait_cnt == 0);
    for (int w = 0; w < 4; w++) fetch_rdata[127-32*w -: 32] = ls_word(pend_addr + 16'(4*w));
    fetch_gnt   = fetch_req && !pend && ($urandom_range(99, 0) < gnt_pct);
    gnt_addr    = fetch_addr;
    issue_stall = ($urandom_range(99, 0) < stall_pct);
    flush       = ($urandom_range(99, 0) < flush_pct);
    flush_pc    = 16'($urandom);
    reset       = hold_rst || ($urandom_range(999, 0) < rst_pct);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      bit          ev1, ev2, ereq;
      logic [31:0] ei1, ei2;
      logic [15:0] ep1, ep2, ea;
      ev1  = (mq.size() >= 1);
      ev2  = (mq.size() >= 2);
      ei1  = ev1 ? mq[0].inst : 32'h0;
      ep1  = ev1 ? mq[0].pc   : 16'h0;
      ei2  = ev2 ? mq[1].inst : 32'h0;
      ep2  = ev2 ? mq[1].pc   : 16'h0;
      ereq = (mphase == 1);
      ea   = ereq ? {mfpc[15:4], 4'h0} : 16'h0;
      check("slot1", {inst_valid1, inst1, inst_pc1}, {ev1, ei1, ep1});
      check("slot2", {inst_valid2, inst2, inst_pc2}, {ev2, ei2, ep2});
      check("fetch", {fetch_req, (ereq ? fetch_addr : 16'h0)}, {ereq, ea});
      check("count_bound", 64'(dut.count_reg <= 4'(DEPTH)), 64'd1);
    end
  end

  initial begin
    int k;
    reset = 1'b1; fetch_gnt = 1'b0; fetch_rvalid = 1'b0; fetch_rdata = '0;
    issue_stall = 1'b0; flush = 1'b0; flush_pc = '0;

    // Reset
    repeat (2) cycle();
    check("rst_valid1", inst_valid1, 1'b0);
    check("rst_valid2", inst_valid2, 1'b0);
    check("rst_req", fetch_req, 1'b0);
    hold_rst = 1'b0;

    // First quadword at address 0, 1-cycle latency
    for (k = 0; k < 20 && !fetch_req; k++) cycle();
    check("first_req", fetch_req, 1'b1);
    check("first_addr", fetch_addr, 16'h0000);
    for (k = 0; k < 20 && !inst_valid1; k++) cycle();
    check("qw0_s1", {inst_valid1, inst1, inst_pc1}, {1'b1, 32'h1, 16'h0000});
    check("qw0_s2", {inst_valid2, inst2, inst_pc2}, {1'b1, 32'h2, 16'h0004});
    cycle();
    check("qw0_s1b", {inst1, inst_pc1}, {32'h3, 16'h0008});
    check("qw0_s2b", {inst2, inst_pc2}, {32'h4, 16'h000C});

    // Stall: outputs frozen while the next quadword fills the buffer
    stall_pct = 100; issue_stall = 1'b1;
    repeat (10) begin
      cycle();
      check("stall_s1", {inst_valid1, inst1, inst_pc1}, {1'b1, 32'h3, 16'h0008});
      check("stall_s2", {inst_valid2, inst2, inst_pc2}, {1'b1, 32'h4, 16'h000C});
    end
    check("stall_noreq", fetch_req, 1'b0);
    stall_pct = 0; issue_stall = 1'b0;
    for (k = 0; k < 20 && !fetch_req; k++) cycle();
    check("next_addr", fetch_addr, 16'h0020);

    // Flush to 0x0108 while a response is outstanding
    lat_min = 3; lat_max = 3;
    for (k = 0; k < 30 && !(pend && wait_cnt > 0); k++) cycle();
    check("in_wait", fetch_req, 1'b0);
    flush = 1'b1; flush_pc = 16'h0108;
    cycle();
    for (k = 0; k < 30 && !fetch_req; k++) cycle();
    check("flush_addr", fetch_addr, 16'h0100);
    for (k = 0; k < 30 && !inst_valid1; k++) cycle();
    check("flush_s1", {inst_valid1, inst1, inst_pc1}, {1'b1, 32'h43, 16'h0108});
    check("flush_s2", {inst_valid2, inst2, inst_pc2}, {1'b1, 32'h44, 16'h010C});

    // Odd count: a single instruction, request held off
    lat_min = 1; lat_max = 1;
    stall_pct = 100; issue_stall = 1'b1;
    flush = 1'b1; flush_pc = 16'h020C;
    cycle();
    for (k = 0; k < 30 && !inst_valid1; k++) cycle();
    gnt_pct = 0;
    repeat (3) cycle();
    check("odd_valid", {inst_valid1, inst_valid2}, 2'b10);
    check("odd_s1", {inst1, inst_pc1}, {32'h84, 16'h020C});
    gnt_pct = 100; stall_pct = 0; issue_stall = 1'b0;
    cycle();
    for (k = 0; k < 30 && !inst_valid1; k++) cycle();
    check("wrap_s1", {inst_valid1, inst1, inst_pc1}, {1'b1, 32'h85, 16'h0210});
    check("wrap_s2", {inst_valid2, inst2, inst_pc2}, {1'b1, 32'h86, 16'h0214});

    // Reset while waiting; the stale response must be ignored
    lat_min = 3; lat_max = 3;
    for (k = 0; k < 30 && !(pend && wait_cnt > 0); k++) cycle();
    hold_rst = 1'b1; reset = 1'b1;
    cycle();
    hold_rst = 1'b0;
    for (k = 0; k < 30 && !fetch_gnt; k++) cycle();
    check("rst_wait_gnt", fetch_gnt, 1'b1);
    check("rst_wait_addr", fetch_addr, 16'h0000);
    check("rst_wait_empty", inst_valid1, 1'b0);

    // Randomized traffic
    gnt_pct = 70; lat_min = 1; lat_max = 4; stall_pct = 30; flush_pct = 3; rst_pct = 4;
    repeat (4000) begin
      salt = 16'($urandom);
      cycle();
    end
    rst_pct = 0; flush_pct = 0;
    repeat (20) cycle();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
